// File: rtl/irq_ctrl_pkg.sv
// Shared types and constants for the interrupt controller.
package irq_ctrl_pkg;

   // Request/service life cycle of one interrupt
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REQ    = 2'd1,
      ACTIVE = 2'd2,
      DELAY  = 2'd3
   } irq_state_e;

   // CSR map
   localparam logic [1:0] CSR_MASK  = 2'd0;
   localparam logic [1:0] CSR_TIMER = 2'd1;
   localparam logic [1:0] CSR_PRIO  = 2'd2;
   localparam logic [1:0] CSR_PEND  = 2'd3;

   // Fixed source IDs
   localparam int IRQ_TIMER    = 0;
   localparam int IRQ_EBREAK   = 1;
   localparam int IRQ_BUSERROR = 2;

endpackage

// File: rtl/irq_ctrl_if.sv
// Core-side bus of the interrupt controller: CSR port plus req/ack/retire handshake.
interface irq_ctrl_if #(
   parameter int NUM_IRQ = 32
) ();
   localparam int IDW = $clog2(NUM_IRQ);

   logic               csr_we;
   logic [1:0]         csr_addr;
   logic [31:0]        csr_wdata;
   logic [31:0]        csr_rdata;
   logic               irq_req;
   logic [IDW-1:0]     irq_id;
   logic               irq_ack;
   logic               irq_retire;
   logic               irq_active;
   logic [NUM_IRQ-1:0] eoi;

   // Core side
   modport master (
      output csr_we, csr_addr, csr_wdata, irq_ack, irq_retire,
      input  csr_rdata, irq_req, irq_id, irq_active, eoi
   );

   // Controller side
   modport slave (
      input  csr_we, csr_addr, csr_wdata, irq_ack, irq_retire,
      output csr_rdata, irq_req, irq_id, irq_active, eoi
   );
endinterface

// File: rtl/irq_prio_arb.sv
// Combinational priority arbiter: highest priority wins, lowest index breaks ties.
module irq_prio_arb #(
   parameter int NUM_IRQ   = 32,
   parameter int PRIO_BITS = 2
) (
   input  logic [NUM_IRQ-1:0]                i_elig,
   input  logic [NUM_IRQ-1:0][PRIO_BITS-1:0] i_prio,
   output logic                              o_vld,
   output logic [$clog2(NUM_IRQ)-1:0]        o_id
);
   localparam int IDW = $clog2(NUM_IRQ);

   logic                 w_vld;
   logic [IDW-1:0]       w_id;
   logic [PRIO_BITS-1:0] w_best;

   // Ascending scan; only a strictly higher priority displaces the current pick
   always_comb begin
      w_vld  = 1'b0;
      w_id   = '0;
      w_best = '0;
      for (int i = 0; i < NUM_IRQ; i++) begin
         if (i_elig[i] && (!w_vld || (i_prio[i] > w_best))) begin
            w_vld  = 1'b1;
            w_id   = IDW'(i);
            w_best = i_prio[i];
         end
      end
   end

   assign o_vld = w_vld;
   assign o_id  = w_id;

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: pending capture, countdown timer, CSRs, arbitration
// and the request/service handshake towards the core.
module irq_ctrl
   import irq_ctrl_pkg::*;
#(
   parameter int          NUM_IRQ          = 32,
   parameter int          PRIO_BITS        = 2,
   parameter logic [31:0] MASKED_IRQ       = 32'h0,
   parameter logic [31:0] LATCHED_IRQ      = 32'hffff_ffff,
   parameter bit          ENABLE_IRQ_TIMER = 1'b1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_IRQ-1:0] irq,
   output logic [NUM_IRQ-1:0] irq_pending,
   irq_ctrl_if.slave          bus
);
   localparam int                 IDW       = $clog2(NUM_IRQ);
   localparam logic [NUM_IRQ-1:0] HARD_MASK = MASKED_IRQ[NUM_IRQ-1:0];
   localparam logic [NUM_IRQ-1:0] LATCH_EN  = LATCHED_IRQ[NUM_IRQ-1:0];

   irq_state_e                        r_state, w_state_nxt;
   logic [NUM_IRQ-1:0]                r_mask;
   logic [NUM_IRQ-1:0]                r_pend, w_pend_nxt;
   logic [NUM_IRQ-1:0][PRIO_BITS-1:0] r_prio;
   logic [31:0]                       r_timer;

   logic                              r_req, w_req_nxt;
   logic [IDW-1:0]                    r_id, w_id_nxt;
   logic                              r_active, w_active_nxt;
   logic [NUM_IRQ-1:0]                r_eoi, w_eoi_nxt;

   logic                              w_wr_mask, w_wr_tmr, w_wr_prio;
   logic [IDW-1:0]                    w_prio_id;
   logic                              w_tmr_fire;
   logic [NUM_IRQ-1:0]                w_set, w_clr, w_elig, w_id_onehot;
   logic                              w_arb_vld;
   logic [IDW-1:0]                    w_arb_id;
   logic                              w_ack;
   logic [31:0]                       w_rdata;

   assign w_wr_mask   = bus.csr_we && (bus.csr_addr == CSR_MASK);
   assign w_wr_tmr    = bus.csr_we && (bus.csr_addr == CSR_TIMER);
   assign w_wr_prio   = bus.csr_we && (bus.csr_addr == CSR_PRIO);
   assign w_prio_id   = bus.csr_wdata[IDW+7:8];
   assign w_id_onehot = {{(NUM_IRQ-1){1'b0}}, 1'b1} << r_id;

   // A reload in the expiry cycle suppresses the timer interrupt
   assign w_tmr_fire  = ENABLE_IRQ_TIMER && (r_timer == 32'd1) && !w_wr_tmr;

   // Sources that raise pending this cycle: the lines plus the timer expiry
   always_comb begin
      w_set            = irq;
      w_set[IRQ_TIMER] = irq[IRQ_TIMER] | w_tmr_fire;
   end

   // Ack clears only the latched bit of the accepted ID; a new set the same cycle wins
   assign w_clr      = w_ack ? w_id_onehot : '0;
   assign w_pend_nxt = (w_set | (r_pend & ~w_clr & LATCH_EN)) & ~HARD_MASK;
   assign w_elig     = r_pend & ~r_mask;

   // Pending vector
   always_ff @(posedge clk) begin
      if (reset) r_pend <= '0;
      else       r_pend <= w_pend_nxt;
   end

   // Software mask, all sources masked out of reset
   always_ff @(posedge clk) begin
      if (reset)          r_mask <= '1;
      else if (w_wr_mask) r_mask <= bus.csr_wdata[NUM_IRQ-1:0];
   end

   // Countdown timer; held at zero when the timer is not built in
   always_ff @(posedge clk) begin
      if (reset || !ENABLE_IRQ_TIMER) r_timer <= '0;
      else if (w_wr_tmr)              r_timer <= bus.csr_wdata;
      else if (r_timer != '0)         r_timer <= r_timer - 32'd1;
   end

   // Per-source priority, addressed by the ID field; out-of-range IDs are dropped
   always_ff @(posedge clk) begin
      if (reset)
         r_prio <= '0;
      else if (w_wr_prio && (int'(w_prio_id) < NUM_IRQ))
         r_prio[w_prio_id] <= bus.csr_wdata[PRIO_BITS-1:0];
   end

   irq_prio_arb #(
      .NUM_IRQ   (NUM_IRQ),
      .PRIO_BITS (PRIO_BITS)
   ) u_arb (
      .i_elig (w_elig),
      .i_prio (r_prio),
      .o_vld  (w_arb_vld),
      .o_id   (w_arb_id)
   );

   // Handshake next state; masking the requested ID withdraws it even if acked
   always_comb begin
      w_state_nxt  = r_state;
      w_req_nxt    = r_req;
      w_id_nxt     = r_id;
      w_active_nxt = r_active;
      w_eoi_nxt    = r_eoi;
      w_ack        = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_arb_vld) begin
               w_id_nxt    = w_arb_id;
               w_req_nxt   = 1'b1;
               w_state_nxt = REQ;
            end
         end
         REQ: begin
            if (w_wr_mask && bus.csr_wdata[r_id]) begin
               w_req_nxt   = 1'b0;
               w_state_nxt = IDLE;
            end else if (bus.irq_ack) begin
               w_ack        = 1'b1;
               w_req_nxt    = 1'b0;
               w_active_nxt = 1'b1;
               w_eoi_nxt    = w_id_onehot;
               w_state_nxt  = ACTIVE;
            end
         end
         ACTIVE: begin
            if (bus.irq_retire) begin
               w_active_nxt = 1'b0;
               w_eoi_nxt    = '0;
               w_state_nxt  = DELAY;
            end
         end
         DELAY:   w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // State and registered handshake outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= IDLE;
         r_req    <= 1'b0;
         r_id     <= '0;
         r_active <= 1'b0;
         r_eoi    <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_req    <= w_req_nxt;
         r_id     <= w_id_nxt;
         r_active <= w_active_nxt;
         r_eoi    <= w_eoi_nxt;
      end
   end

   // CSR read mux, zero-extended; the priority CSR is write-only
   always_comb begin
      w_rdata = '0;
      case (bus.csr_addr)
         CSR_MASK:  w_rdata[NUM_IRQ-1:0] = r_mask;
         CSR_TIMER: w_rdata              = r_timer;
         CSR_PRIO:  w_rdata              = '0;
         CSR_PEND:  w_rdata[NUM_IRQ-1:0] = r_pend;
         default:   w_rdata              = '0;
      endcase
   end

   assign bus.csr_rdata  = w_rdata;
   assign bus.irq_req    = r_req;
   assign bus.irq_id     = r_id;
   assign bus.irq_active = r_active;
   assign bus.eoi        = r_eoi;
   assign irq_pending    = r_pend;

endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Parametrised interrupt controller: the next generation of the core's IRQ logic, generalised to `NUM_IRQ` sources with per-source programmable priority, per-source latched/level mode and a built-in countdown timer. It sits between the external IRQ lines and the CPU fetch state machine. It arbitrates pending unmasked sources, presents one request with its ID to the core through a req/ack handshake, and tracks the in-service interrupt until the core retires the handler.

## Interface
- `NUM_IRQ`, 32: number of sources. Legal range 3..32. Source 0 is the timer, source 1 is ebreak, source 2 is bus error.
- `PRIO_BITS`, 2: priority field width per source. A higher value means a higher priority.
- `MASKED_IRQ`, 32'h0: sources hard-masked. They never become pending.
- `LATCHED_IRQ`, 32'hffff_ffff: bit = 1 makes the source sticky (latched). Bit = 0 makes the pending bit follow the level.
- `ENABLE_IRQ_TIMER`, 1: enables the countdown timer.
- `IDW`, derived: `$clog2(NUM_IRQ)`.

Ports:
- `clk` in 1: clock. All logic is on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `irq` in NUM_IRQ: raw interrupt lines, already synchronous to `clk`.
- `csr_we` in 1: CSR write strobe.
- `csr_addr` in 2: CSR select. 0 = mask, 1 = timer, 2 = priority, 3 = pending (read-only).
- `csr_wdata` in 32: write data. For priority: bits [IDW+7:8] = source ID, bits [PRIO_BITS-1:0] = priority value.
- `csr_rdata` out 32: combinational read of the selected CSR, zero-extended. Address 2 reads 0.
- `irq_req` out 1: request to the core.
- `irq_id` out IDW: ID of the requested source. Stable while `irq_req` is high.
- `irq_ack` in 1: core accepts the request.
- `irq_retire` in 1: core finished the handler (retirq).
- `irq_active` out 1: a handler is in service.
- `eoi` out NUM_IRQ: one-hot of the in-service source.
- `irq_pending` out NUM_IRQ: current pending vector.

## Operation
- **Pending vector.**
  - Latched source: the bit is set on any cycle where its `irq` bit is 1. It is cleared only when that source is acked.
  - Level source: `pending[i] = irq[i]` registered.
  - A bit set in `MASKED_IRQ` forces the pending bit to 0.
- **Timer.**
  - 32-bit down-counter, loaded by a CSR write to address 1.
  - It decrements every cycle while nonzero.
  - The 1→0 transition sets `pending[0]`. Writing 0 disables the timer.
- **Eligible sources:** `pending & ~mask`. The arbiter picks the highest priority; ties go to the lowest ID.
- **FSM states:**
  - `IDLE`: if any source is eligible, register the winner into `irq_id`, set `irq_req`, go to `REQ`.
  - `REQ`:
    - On `irq_ack`: clear the latched pending bit of `irq_id`, set `eoi` to the one-hot of the ID, drop `irq_req`, raise `irq_active`, go to `ACTIVE`.
    - If a mask write masks `irq_id`: drop `irq_req` and go to `IDLE` instead.
  - `ACTIVE`: on `irq_retire`, clear `irq_active` and `eoi`, go to `DELAY`. There is no nesting; new requests wait.
  - `DELAY`: one cycle, then `IDLE`. This guarantees the core executes at least one instruction between handlers.
- **Simultaneous events:**
  - A latched `irq[i]` high in the same cycle as the ack-clear of bit i: the set wins, and the bit stays pending.
  - A CSR timer write in the same cycle as the 1→0 transition: the write wins, and no pending bit is set.
  - `irq_ack` outside `REQ` is ignored.
  - `irq_retire` outside `ACTIVE` is ignored.
- **Reset values:**
  - FSM = `IDLE`, mask = all ones, timer = 0, priorities = 0, pending = 0.
  - `irq_req` = 0, `irq_id` = 0, `irq_active` = 0, `eoi` = 0.
  - Reset asserted mid-handler aborts everything in the next cycle.

## Timing
- Latency from `irq[i]` high to `irq_req` high is 2 cycles: the pending register, then the request register.
- `irq_req` is held until ack or withdrawal. The core may take any number of cycles to ack.
- The ack takes effect at the edge where `irq_ack && irq_req`. `irq_active` and `eoi` are valid the next cycle.
- After retire, the earliest next `irq_req` is 2 cycles later (`DELAY` → `IDLE` → `REQ`).
- CSR writes take effect on the following cycle. `csr_rdata` is combinational from the registers.

## Structure
- Package `irq_ctrl_pkg`:
  - FSM state enum (`IDLE`, `REQ`, `ACTIVE`, `DELAY`).
  - CSR address constants.
  - Fixed source IDs (`IRQ_TIMER` = 0, `IRQ_EBREAK` = 1, `IRQ_BUSERROR` = 2).
- Sub-module `irq_prio_arb`: combinational arbiter. Inputs are the eligible vector and the flattened priority array. Outputs are a valid flag and the winner ID, using max priority with the lowest-index tiebreak.

## Test plan
- **Single source:** reset, mask = 0, pulse `irq[5]` for 1 cycle → `irq_req` = 1 with `irq_id` = 5 two cycles later. Ack → `eoi` = 0x20, `irq_active` = 1. `pending[5]` stays 0 afterwards.
- **Arbitration:** give source 7 priority 3 and source 4 priority 1, assert both → `irq_id` = 7. After retire plus the 2-cycle gap → `irq_id` = 4. With equal priorities → 4 first.
- **Timer:** write timer = 10 → `pending[0]` sets exactly 10 cycles after the write. A write of 0 in the expiry cycle → no pending.
- **Level vs latched:** `LATCHED_IRQ` = 0 for source 3; assert `irq[3]` for 1 cycle → it clears without service and no request remains.
- **Withdrawal and reset:** in `REQ` for source 9, write a mask with bit 9 set → `irq_req` drops the next cycle. Assert `reset` during `ACTIVE` → all outputs return to their reset values the next cycle.
